// File: rtl/quad_carrier_demod_pkg.sv
// Shared definitions for the fs/4 quadrature demodulator.
// Carrier codes are bit-identical to the ones the local carrier generator
// uses, so the modulator and demodulator phase tables cannot drift apart.
//   car_code_t    : 2-bit carrier weight (+1 / 0 / -1)
//   demod_state_t : control FSM state
//   cos_code()    : I-branch carrier weight for a 2-bit phase
//   sin_code()    : Q-branch carrier weight for a 2-bit phase
package quad_carrier_demod_pkg;

    typedef enum logic [1:0] {
        CAR_ZERO = 2'b00,
        CAR_POS  = 2'b01,
        CAR_NEG  = 2'b11
    } car_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } demod_state_t;

    // cos sequence over phases 0..3: +1, 0, -1, 0
    function automatic car_code_t cos_code(input logic [1:0] phase);
        case (phase)
            2'd0:    return CAR_POS;
            2'd2:    return CAR_NEG;
            default: return CAR_ZERO;
        endcase
    endfunction

    // sin sequence over phases 0..3: 0, +1, 0, -1
    function automatic car_code_t sin_code(input logic [1:0] phase);
        case (phase)
            2'd1:    return CAR_POS;
            2'd3:    return CAR_NEG;
            default: return CAR_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/quad_carrier_demod_iq_integrator.sv
// One demodulator branch (iq_integrator): mixes a sample by a carrier
// code, then integrates it and dumps the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : accumulator returns to 0 on the next edge (dump / disable)
//   restart    : current sample starts a new symbol (ignore the old sum)
//   step       : current sample is accepted into the sum
//   code       : carrier weight for the current sample
//   data       : signed received sample
//   sum        : accumulator plus the current mixed sample (dump value)
module quad_carrier_demod_iq_integrator
    import quad_carrier_demod_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 restart,
    input  logic                 step,
    input  car_code_t            code,
    input  logic signed [DW-1:0] data,
    output logic signed [AW-1:0] sum
);

    logic signed [AW-1:0] acc;
    logic signed [DW:0]   data_ext;
    logic signed [DW:0]   mixed;
    logic signed [AW-1:0] base;
    logic signed [AW-1:0] term;

    // One extra bit so that negating the most negative sample stays exact.
    assign data_ext = {data[DW-1], data};

    always_comb begin
        mixed = '0;
        case (code)
            CAR_POS: mixed = data_ext;
            CAR_NEG: mixed = -data_ext;
            default: mixed = '0;
        endcase
    end

    assign base = restart ? '0 : acc;
    assign term = step ? {{(AW-DW-1){mixed[DW]}}, mixed} : '0;
    assign sum  = base + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/quad_carrier_demod.sv
// Coherent fs/4 quadrature demodulator. It mixes each valid sample with an
// internal cos/sin carrier, integrates over SPS valid samples and then
// emits I/Q soft sums and hard-decision bits once per symbol.
//   clk, rst_n           : clock, asynchronous active-low reset
//   en                   : block enable; low forces IDLE
//   sync                 : symbol-start strobe (realigns phase and count)
//   in_valid, in_data    : qualified signed input sample
//   busy                 : high while in RUN
//   sym_valid            : 1-cycle pulse when sym_* / acc_*_out update
//   sym_i, sym_q         : hard bits (1 = negative sum)
//   acc_i_out, acc_q_out : signed soft sums of the last symbol
module quad_carrier_demod
    import quad_carrier_demod_pkg::*;
#(
    parameter  int DW  = 8,
    parameter  int SPS = 16,
    localparam int AW  = DW + $clog2(SPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 busy,
    output logic                 sym_valid,
    output logic                 sym_i,
    output logic                 sym_q,
    output logic signed [AW-1:0] acc_i_out,
    output logic signed [AW-1:0] acc_q_out
);

    localparam int CW = $clog2(SPS);

    demod_state_t         state;
    logic [1:0]           phase;
    logic [CW-1:0]        count;
    logic                 run;
    logic                 start;
    logic                 take;
    logic                 dump;
    logic                 restart;
    logic                 clear;
    logic [1:0]           phase_cur;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;

    assign run   = (state == RUN) && en;
    assign start = en && sync;
    assign take  = in_valid && (run || start);
    // A sync on the dump sample lets the old symbol finish; the new symbol
    // then begins with the following valid sample at phase 0.
    assign dump    = run && in_valid && (count == CW'(SPS - 1));
    assign restart = start && !dump;
    assign clear   = !en || dump;
    assign phase_cur = restart ? 2'd0 : phase;
    assign busy    = (state == RUN);

    quad_carrier_demod_iq_integrator #(.DW(DW), .AW(AW)) u_int_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .restart (restart),
        .step    (take),
        .code    (cos_code(phase_cur)),
        .data    (in_data),
        .sum     (sum_i)
    );

    quad_carrier_demod_iq_integrator #(.DW(DW), .AW(AW)) u_int_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .restart (restart),
        .step    (take),
        .code    (sin_code(phase_cur)),
        .data    (in_data),
        .sum     (sum_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= 2'd0;
            count     <= '0;
            sym_valid <= 1'b0;
            sym_i     <= 1'b0;
            sym_q     <= 1'b0;
            acc_i_out <= '0;
            acc_q_out <= '0;
        end else begin
            sym_valid <= dump;
            if (dump) begin
                acc_i_out <= sum_i;
                acc_q_out <= sum_q;
                sym_i     <= sum_i[AW-1];
                sym_q     <= sum_q[AW-1];
            end

            if (!en) begin
                state <= IDLE;
                phase <= 2'd0;
                count <= '0;
            end else if (dump) begin
                state <= RUN;
                phase <= 2'd0;
                count <= '0;
            end else if (start) begin
                // sample on the sync cycle (if any) is sample 0 at phase 0
                state <= RUN;
                phase <= in_valid ? 2'd1 : 2'd0;
                count <= in_valid ? CW'(1) : '0;
            end else if (state == RUN && in_valid) begin
                phase <= phase + 2'd1;
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_carrier_demod.sv
module tb_quad_carrier_demod;

    localparam int DW  = 8;
    localparam int SPS = 16;
    localparam int AW  = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 sync;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 busy;
    logic                 sym_valid;
    logic                 sym_i;
    logic                 sym_q;
    logic signed [AW-1:0] acc_i_out;
    logic signed [AW-1:0] acc_q_out;

    quad_carrier_demod #(.DW(DW), .SPS(SPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .sym_valid (sym_valid),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .acc_i_out (acc_i_out),
        .acc_q_out (acc_q_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int ai;
        int aq;
        bit si;
        bit sq;
        int due;
    } exp_t;

    typedef struct {
        int pat[4];
        bit sparse;
        int ai;
        int aq;
        bit si;
        bit sq;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[6];
    int   checks = 0;
    int   errors = 0;
    bit   prev_v = 1'b0;
    int   last_ai = 0;
    int   last_aq = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (sym_valid) begin
            if (prev_v) begin
                checks++;
                errors++;
                $display("FAIL back_to_back_pulse: got 2 consecutive expected 1 (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got acc_i=%0d acc_q=%0d expected no pulse (cycle %0d)",
                         acc_i_out, acc_q_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("acc_i", acc_i_out, e.ai);
                chk("acc_q", acc_q_out, e.aq);
                chk("sym_i", sym_i, e.si);
                chk("sym_q", sym_q, e.sq);
                chk("pulse_cycle", cyc, e.due);
            end
        end
        prev_v = sym_valid;
    end

    // Record an expectation for a pulse one clock after the sample driven next.
    task automatic expect_pulse(input int ai, input int aq, input bit si, input bit sq);
        exp_t x;
        x.ai = ai; x.aq = aq; x.si = si; x.sq = sq; x.due = cyc + 1;
        sb.push_back(x);
        last_ai = ai;
        last_aq = aq;
    endtask

    task automatic put(input int x, input bit s);
        in_valid = 1'b1;
        sync     = s;
        in_data  = x[7:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        sync     = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input int idx, input bit do_sync);
        for (int k = 0; k < SPS; k++) begin
            if (k == SPS - 1)
                expect_pulse(tbl[idx].ai, tbl[idx].aq, tbl[idx].si, tbl[idx].sq);
            put(tbl[idx].pat[k % 4], do_sync && (k == 0));
            if (tbl[idx].sparse) gap(1);
        end
        gap(3);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sym_valid"}, sym_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sym_i"}, sym_i, 0);
        chk({tag, "_sym_q"}, sym_q, 0);
        chk({tag, "_acc_i"}, acc_i_out, 0);
        chk({tag, "_acc_q"}, acc_q_out, 0);
    endtask

    initial begin
        int si_sum, sq_sum, x, p;

        tbl[0] = '{pat: '{20, 0, -20, 0},     sparse: 0, ai: 160,   aq: 0,    si: 0, sq: 0};
        tbl[1] = '{pat: '{0, -20, 0, 20},     sparse: 0, ai: 0,     aq: -160, si: 0, sq: 1};
        tbl[2] = '{pat: '{-128, 0, 127, 0},   sparse: 0, ai: -1020, aq: 0,    si: 1, sq: 0};
        tbl[3] = '{pat: '{0, -20, 0, 20},     sparse: 1, ai: 0,     aq: -160, si: 0, sq: 1};
        tbl[4] = '{pat: '{127, 127, -128, -128}, sparse: 0, ai: 1020, aq: 1020, si: 0, sq: 0};
        tbl[5] = '{pat: '{100, 100, 100, 100}, sparse: 0, ai: 0,    aq: 0,    si: 0, sq: 0};

        // Reset held with random activity on the inputs.
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 6; i++) begin
            en       = 1'($urandom);
            sync     = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(posedge clk); #1;
            chk_all_zero("in_reset");
        end
        rst_n = 1'b1; en = 1'b1; sync = 1'b0;

        // Enabled but never synced: no pulse, stays idle.
        for (int i = 0; i < 20; i++) put($urandom_range(0, 255), 1'b0);
        chk("idle_busy", busy, 0);

        // Table of full symbols.
        for (int v = 0; v < 6; v++) begin
            run_vec(v, 1'b1);
            chk("busy_run", busy, 1);
        end

        // 32 continuous random samples after one sync.
        si_sum = 0; sq_sum = 0;
        for (int k = 0; k < 2 * SPS; k++) begin
            x = int'($signed(8'($urandom)));
            p = k % 4;
            si_sum += (p == 0) ? x : ((p == 2) ? -x : 0);
            sq_sum += (p == 1) ? x : ((p == 3) ? -x : 0);
            if (k % SPS == SPS - 1) begin
                expect_pulse(si_sum, sq_sum, si_sum < 0, sq_sum < 0);
                si_sum = 0; sq_sum = 0;
            end
            put(x, k == 0);
        end
        gap(3);

        // Partial symbol abandoned by a new sync after 7 samples.
        for (int k = 0; k < 7; k++) put($urandom_range(0, 255), k == 0);
        run_vec(1, 1'b1);

        // Sync coincident with the dump sample: old symbol completes,
        // next symbol starts at phase 0 without another sync.
        for (int k = 0; k < SPS - 1; k++) put(tbl[0].pat[k % 4], k == 0);
        expect_pulse(160, 0, 0, 0);
        put(tbl[0].pat[3], 1'b1);
        run_vec(1, 1'b0);

        // Disable mid-symbol: held outputs stay, busy drops, no pulse.
        for (int k = 0; k < 5; k++) put(tbl[2].pat[k % 4], k == 0);
        en = 1'b0;
        gap(2);
        chk("dis_busy", busy, 0);
        chk("dis_hold_acc_i", acc_i_out, last_ai);
        chk("dis_hold_acc_q", acc_q_out, last_aq);
        for (int i = 0; i < 6; i++) put($urandom_range(0, 255), 1'($urandom));
        en = 1'b1;
        run_vec(2, 1'b1);

        // Asynchronous reset mid-symbol.
        for (int k = 0; k < 9; k++) put(tbl[4].pat[k % 4], k == 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) put($urandom_range(0, 255), 1'b0);
        chk("post_rst_busy", busy, 0);
        run_vec(0, 1'b1);

        gap(5);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish before 200000");
        $fatal(1);
    end

endmodule
